// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
//
// Round-robin arbiter sharing one AXI-Stream output between NI requesters.
// The output is a single registered slot. A new beat can be accepted in the
// same cycle the current one drains, so throughput is one beat per cycle.
// m_axis_tid reports which requester supplied the beat.
//
// Optional feature (macro STREAM_RR_ARBITER_PACKET_LOCK_EN):
//   When the macro is defined, a grant is held for a whole tlast-delimited
//   packet, and the round-robin pointer only advances when the packet ends.
//   When it is undefined, arbitration is per beat and tlast is forwarded only.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   NI*DW  requester data, requester i at [i*DW +: DW]
//   s_axis_tvalid  NI     per-requester valid
//   s_axis_tlast   NI     per-requester end-of-packet
//   s_axis_tready  NI     per-requester ready (combinational, one-hot or zero)
//   m_axis_tdata   DW     registered output data
//   m_axis_tid     IW     source index of the output beat
//   m_axis_tlast   1      registered tlast
//   m_axis_tvalid  1      output valid
//   m_axis_tready  1      downstream ready
// ---------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int NI = 4,
    parameter int DW = 24,
    localparam int IW = $clog2(NI)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NI*DW-1:0] s_axis_tdata,
    input  logic [NI-1:0]    s_axis_tvalid,
    input  logic [NI-1:0]    s_axis_tlast,
    output logic [NI-1:0]    s_axis_tready,
    output logic [DW-1:0]    m_axis_tdata,
    output logic [IW-1:0]    m_axis_tid,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic [IW-1:0] ptr_reg;      // round-robin start index
    logic [IW-1:0] rr_sel;       // first valid requester from ptr_reg
    logic          rr_found;
    logic [IW-1:0] grant_idx;    // requester actually granted this cycle
    logic          grant_any;
    logic          slot_free;
    logic          accept;
    logic [DW-1:0] grant_data;
    logic          grant_last;
    logic [IW-1:0] ptr_inc;

    // Rotating priority scan. Iterating from the farthest offset down to 0
    // lets the nearest valid requester (smallest offset) overwrite the rest.
    always_comb begin
        int idx;
        rr_sel   = '0;
        rr_found = 1'b0;
        idx      = 0;
        for (int k = NI - 1; k >= 0; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NI) begin
                idx = idx - NI;
            end
            if (s_axis_tvalid[idx]) begin
                rr_sel   = IW'(idx);
                rr_found = 1'b1;
            end
        end
    end

`ifdef STREAM_RR_ARBITER_PACKET_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t   state_reg;
    logic [IW-1:0] lk_reg;       // requester owning the packet in progress

    // While locked, only the owner may be granted, even if it is idle.
    always_comb begin
        if (state_reg == LOCKED) begin
            grant_idx = lk_reg;
            grant_any = s_axis_tvalid[lk_reg];
        end else begin
            grant_idx = rr_sel;
            grant_any = rr_found;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            lk_reg    <= '0;
        end else if (accept) begin
            if (grant_last) begin
                state_reg <= IDLE;
            end else begin
                state_reg <= LOCKED;
                lk_reg    <= grant_idx;
            end
        end
    end
`else
    assign grant_idx = rr_sel;
    assign grant_any = rr_found;
`endif

    assign slot_free  = !m_axis_tvalid || m_axis_tready;
    // rst_n gates accept so no ready is offered while reset is held.
    assign accept     = grant_any && slot_free && rst_n;
    assign grant_data = s_axis_tdata[grant_idx*DW +: DW];
    assign grant_last = s_axis_tlast[grant_idx];
    assign ptr_inc    = (int'(grant_idx) == NI - 1) ? '0 : grant_idx + 1'b1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_ready
        assign s_axis_tready[gi] = accept && (grant_idx == IW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            if (accept) begin
                m_axis_tdata  <= grant_data;
                m_axis_tid    <= grant_idx;
                m_axis_tlast  <= grant_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
`ifdef STREAM_RR_ARBITER_PACKET_LOCK_EN
            // Mid-packet beats leave the pointer where it is.
            if (accept && grant_last) begin
                ptr_reg <= ptr_inc;
            end
`else
            if (accept) begin
                ptr_reg <= ptr_inc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Self-checking bench for stream_rr_arbiter (NI=4, DW=24). It runs in four
// parts: a table of directed cycle vectors, a hand-written packet sequence
// (expectations depend on STREAM_RR_ARBITER_PACKET_LOCK_EN), an asynchronous
// reset check, and a randomized run. The randomized run is checked against a
// behavioural arbiter model and a per-source sequence scoreboard.
// ---------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int NI     = 4;
    localparam int DW     = 24;
    localparam int IW     = 2;
    localparam int NBEATS = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NI*DW-1:0] s_tdata;
    logic [NI-1:0]    s_tvalid;
    logic [NI-1:0]    s_tlast;
    logic [NI-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [IW-1:0]    m_tid;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NI(NI), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tid    (m_tid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NI-1:0] valid;
        logic [NI-1:0] last;
        logic          mready;
        logic [NI-1:0] exp_ready;
        logic          exp_mvalid;
        logic [IW-1:0] exp_tid;
        logic [DW-1:0] exp_data;
        logic          exp_mlast;
    } vec_t;

    // Directed vectors always drive requester i with data 0x10+i.
    function automatic vec_t mk(input logic [NI-1:0] v, input logic [NI-1:0] l, input logic mr,
                                input logic [NI-1:0] er, input logic emv, input int etid,
                                input logic elast);
        vec_t r;
        r.valid      = v;
        r.last       = l;
        r.mready     = mr;
        r.exp_ready  = er;
        r.exp_mvalid = emv;
        r.exp_tid    = IW'(etid);
        r.exp_data   = DW'(32'h10 + etid);
        r.exp_mlast  = elast;
        return r;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        s_tvalid = v.valid;
        s_tlast  = v.last;
        m_tready = v.mready;
        for (int i = 0; i < NI; i++) s_tdata[i*DW +: DW] = DW'(32'h10 + i);
        #1;
        check({tag, " s_tready"}, 32'(s_tready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        check({tag, " m_tvalid"}, 32'(m_tvalid), 32'(v.exp_mvalid));
        check({tag, " m_tid"}, 32'(m_tid), 32'(v.exp_tid));
        check({tag, " m_tdata"}, 32'(m_tdata), 32'(v.exp_data));
        check({tag, " m_tlast"}, 32'(m_tlast), 32'(v.exp_mlast));
        $display("%s: valid=%b ready=%b -> mvalid=%0b tid=%0d data=%06h last=%0b",
                 tag, v.valid, s_tready, m_tvalid, m_tid, m_tdata, m_tlast);
    endtask

    // Randomized-phase state
    int  cur_n   [NI];
    bit  pres    [NI];
    int  exp_seq [NI];
    bit  lastbits[NI][NBEATS];

    initial begin
        vec_t tbl[$];
        vec_t seq[$];
        int   mptr, mlk, mtid, cand, cycles, t, idx;
        bit   mlocked, mv, mlast, acc, done;
        logic [DW-1:0] mdata;
        logic [NI-1:0] exp_r;

        // ---------------- reset ----------------
        s_tvalid = '1;
        s_tlast  = '1;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset s_tready", 32'(s_tready), 32'h0);
        check("reset m_tvalid", 32'(m_tvalid), 32'h0);
        check("reset m_tdata", 32'(m_tdata), 32'h0);
        check("reset m_tid", 32'(m_tid), 32'h0);
        check("reset m_tlast", 32'(m_tlast), 32'h0);
        @(negedge clk);
        s_tvalid = '0;
        rst_n    = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("idle m_tvalid", 32'(m_tvalid), 32'h0);
            check("idle s_tready", 32'(s_tready), 32'h0);
        end

        // ---------------- directed table ----------------
        for (int k = 0; k < 8; k++) tbl.push_back(mk(4'hF, 4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, k % 4, 1'b1));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 3, 1'b1));
        // stall with requesters 1 and 3
        tbl.push_back(mk(4'hA, 4'hF, 1'b0, 4'b0010, 1'b1, 1, 1'b1));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(4'hA, 4'hF, 1'b0, 4'b0000, 1'b1, 1, 1'b1));
        tbl.push_back(mk(4'hA, 4'hF, 1'b1, 4'b1000, 1'b1, 3, 1'b1));
        tbl.push_back(mk(4'hA, 4'hF, 1'b1, 4'b0010, 1'b1, 1, 1'b1));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 1, 1'b1));
        // single-beat packets from 0 and 2 interleave
        tbl.push_back(mk(4'h5, 4'hF, 1'b1, 4'b0100, 1'b1, 2, 1'b1));
        tbl.push_back(mk(4'h5, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 1'b1));
        tbl.push_back(mk(4'h5, 4'hF, 1'b1, 4'b0100, 1'b1, 2, 1'b1));
        tbl.push_back(mk(4'h5, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 1'b1));
        tbl.push_back(mk(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 0, 1'b1));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // ---------------- 3-beat packet from requester 2 vs requester 0 ----------------
`ifdef STREAM_RR_ARBITER_PACKET_LOCK_EN
        seq.push_back(mk(4'h5, 4'b1011, 1'b1, 4'b0100, 1'b1, 2, 1'b0));
        seq.push_back(mk(4'h1, 4'b1011, 1'b1, 4'b0000, 1'b0, 2, 1'b0)); // owner idle: 0 waits
        seq.push_back(mk(4'h5, 4'b1011, 1'b1, 4'b0100, 1'b1, 2, 1'b0));
        seq.push_back(mk(4'h5, 4'hF,    1'b1, 4'b0100, 1'b1, 2, 1'b1));
        seq.push_back(mk(4'h1, 4'hF,    1'b1, 4'b0001, 1'b1, 0, 1'b1));
`else
        seq.push_back(mk(4'h5, 4'b1011, 1'b1, 4'b0100, 1'b1, 2, 1'b0));
        seq.push_back(mk(4'h5, 4'b1011, 1'b1, 4'b0001, 1'b1, 0, 1'b1));
        seq.push_back(mk(4'h5, 4'b1011, 1'b1, 4'b0100, 1'b1, 2, 1'b0));
        seq.push_back(mk(4'h5, 4'hF,    1'b1, 4'b0001, 1'b1, 0, 1'b1));
`endif
        seq.push_back(mk(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 0, 1'b1));
        for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("pkt%0d", i));

        // ---------------- asynchronous reset mid-transfer ----------------
        // Requester 1 starts a packet so ptr (and any lock) is non-trivial.
        apply(mk(4'h2, 4'h0, 1'b0, 4'b0010, 1'b1, 1, 1'b0), "pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst m_tvalid", 32'(m_tvalid), 32'h0);
        check("async rst s_tready", 32'(s_tready), 32'h0);
        @(negedge clk);
        s_tvalid = '0;
        rst_n    = 1'b1;
        apply(mk(4'h9, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 1'b1), "post_rst");
        apply(mk(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 0, 1'b1), "post_rst_drain");

        // ---------------- randomized run ----------------
        @(negedge clk);
        rst_n = 1'b0;
        s_tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            cur_n[i] = 0;
            pres[i] = 1'b0;
            exp_seq[i] = 0;
            for (int n = 0; n < NBEATS; n++)
                lastbits[i][n] = (n == NBEATS - 1) || ($urandom_range(0, 3) == 0);
        end
        mptr = 0; mlocked = 1'b0; mlk = 0; mv = 1'b0; mtid = 0; mdata = '0; mlast = 1'b0;
        cycles = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!pres[i] && cur_n[i] < NBEATS && $urandom_range(0, 9) < 7) pres[i] = 1'b1;
                s_tvalid[i] = pres[i];
                s_tdata[i*DW +: DW] = DW'((i << 16) | (cur_n[i] & 32'hFFFF));
                s_tlast[i] = pres[i] ? lastbits[i][cur_n[i]] : 1'b0;
            end
            m_tready = 1'($urandom_range(0, 1));
            #1;
            // Scoreboard: each source must arrive in order, once.
            if (m_tvalid && m_tready) begin
                t = int'(m_tid);
                if (exp_seq[t] < NBEATS) begin
                    check("sb data", 32'(m_tdata), 32'((t << 16) | exp_seq[t]));
                    check("sb last", 32'(m_tlast), 32'(lastbits[t][exp_seq[t]]));
                end else begin
                    check("sb extra beat", 32'(exp_seq[t]), 32'(NBEATS - 1));
                end
                $display("beat: tid=%0d data=%06h last=%0b", m_tid, m_tdata, m_tlast);
                exp_seq[t]++;
            end
            // Model: pick the grant from the arbitration rules.
            cand = -1;
            if (mlocked) begin
                if (pres[mlk]) cand = mlk;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    idx = (mptr + k) % NI;
                    if (cand < 0 && pres[idx]) cand = idx;
                end
            end
            acc = (cand >= 0) && (!mv || m_tready);
            exp_r = acc ? NI'(1 << cand) : '0;
            check("rnd s_tready", 32'(s_tready), 32'(exp_r));
            if (acc) begin
                mv = 1'b1;
                mtid = cand;
                mdata = DW'((cand << 16) | cur_n[cand]);
                mlast = lastbits[cand][cur_n[cand]];
`ifdef STREAM_RR_ARBITER_PACKET_LOCK_EN
                if (mlast) begin
                    mlocked = 1'b0;
                    mptr = (cand + 1) % NI;
                end else begin
                    mlocked = 1'b1;
                    mlk = cand;
                end
`else
                mptr = (cand + 1) % NI;
`endif
                cur_n[cand]++;
                pres[cand] = 1'b0;
            end else if (mv && m_tready) begin
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
            check("rnd m_tvalid", 32'(m_tvalid), 32'(mv));
            if (mv) begin
                check("rnd m_tid", 32'(m_tid), 32'(mtid));
                check("rnd m_tdata", 32'(m_tdata), 32'(mdata));
                check("rnd m_tlast", 32'(m_tlast), 32'(mlast));
            end
            cycles++;
            done = !mv;
            for (int i = 0; i < NI; i++) if (cur_n[i] < NBEATS) done = 1'b0;
            if (!done && cycles >= 40000) begin
                checks++;
                errors++;
                $display("FAIL rnd timeout: got %0d cycles expected completion", cycles);
                done = 1'b1;
            end
        end
        for (int i = 0; i < NI; i++) check($sformatf("rnd count src%0d", i), 32'(exp_seq[i]), 32'(NBEATS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
